// File: rtl/req_encoder.sv
// Sequential 4-to-2 request encoder: drains a multi-hot pending set as 2-bit
// indices {A,B}, lowest first, over a valid/ready handshake. It pulses done when the set empties.
module req_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic       req_load,
    input  logic       out_ready,
    output logic       A,
    output logic       B,
    output logic       out_valid,
    output logic       done,
    output logic [2:0] pend_cnt
);

    typedef enum logic [1:0] {IDLE, SERVE, DONE} state_e;

    state_e     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] idx_q, idx_d;
    logic       accept;
    logic [3:0] acc_bit;
    logic [1:0] sel;

    assign out_valid = (state_q == SERVE);
    assign done      = (state_q == DONE);
    assign A         = idx_q[1];
    assign B         = idx_q[0];
    assign pend_cnt  = {2'b00, pending_q[0]} + {2'b00, pending_q[1]}
                     + {2'b00, pending_q[2]} + {2'b00, pending_q[3]};

    // Clear the accepted bit before merging, so a re-request in the accept cycle survives.
    always_comb begin
        accept    = out_valid & out_ready;
        acc_bit   = accept ? (4'b0001 << idx_q) : 4'b0000;
        pending_d = (pending_q & ~acc_bit) | (req_load ? req_in : 4'b0000);
    end

    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_d[i]) sel = 2'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (pending_d != 4'b0000) begin
                    state_d = SERVE;
                    idx_d   = sel;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                // Without an accept the presented index holds, even if a lower bit merges in.
                if (accept) begin
                    if (pending_d != 4'b0000) idx_d = sel;
                    else                      state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            idx_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: tb/tb_req_encoder.sv
// Scoreboard bench for req_encoder: the stimulus pushes the expected outputs from a set-based
// reference model, and a monitor pops and compares them after each rising edge.
module tb_req_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in;
    logic       req_load;
    logic       out_ready;
    logic       A, B, out_valid, done;
    logic [2:0] pend_cnt;

    req_encoder dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_load(req_load),
        .out_ready(out_ready), .A(A), .B(B), .out_valid(out_valid),
        .done(done), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        int       idx;
        bit       dn;
        int       cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the pending requests as a bit array, the index being served, and a busy flag.
    bit   m_pend[4];
    bit   m_busy;
    int   m_cur;

    function automatic int lowest();
        for (int i = 0; i < 4; i++) if (m_pend[i]) return i;
        return -1;
    endfunction

    function automatic int count();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_busy = 1'b0;
        m_cur  = 0;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs (no wait) and push the outputs expected after the next edge.
    task automatic apply(input bit ld, input logic [3:0] rq, input bit rdy);
        exp_t e;
        bit   fin;
        req_load  = ld;
        req_in    = rq;
        out_ready = rdy;
        fin = 1'b0;
        if (m_busy && rdy) m_pend[m_cur] = 1'b0;
        if (ld) for (int i = 0; i < 4; i++) if (rq[i]) m_pend[i] = 1'b1;
        if (m_busy) begin
            if (rdy) begin
                if (lowest() >= 0) m_cur = lowest();
                else begin
                    m_busy = 1'b0;
                    fin    = 1'b1;
                end
            end
        end else if (lowest() >= 0) begin
            m_busy = 1'b1;
            m_cur  = lowest();
        end
        e.valid = m_busy;
        e.idx   = m_cur;
        e.dn    = fin;
        e.cnt   = count();
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit ld, input logic [3:0] rq, input bit rdy);
        @(negedge clk);
        apply(ld, rq, rdy);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_valid", int'(out_valid), int'(e.valid));
            check("done", int'(done), int'(e.dn));
            check("pend_cnt", int'(pend_cnt), e.cnt);
            if (e.valid) check("index", int'({A, B}), e.idx);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_A"}, int'(A), 0);
        check({tag, "_B"}, int'(B), 0);
        check({tag, "_cnt"}, int'(pend_cnt), 0);
    endtask

    initial begin
        int wait_cnt;
        rst_n     = 1'b0;
        req_in    = 4'b0000;
        req_load  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1010 with ready high: 01, 11, then done
        cycle(1, 4'b1010, 1);
        cycle(0, 4'b0000, 1);
        cycle(0, 4'b0000, 1);
        cycle(0, 4'b0000, 0);

        // 0110 stalled for three cycles, then drained
        cycle(1, 4'b0110, 0);
        repeat (3) cycle(0, 4'b0000, 0);
        repeat (3) cycle(0, 4'b0000, 1);

        // serving 11 stalled; a lower bit merges but must wait
        cycle(1, 4'b1000, 0);
        cycle(1, 4'b0001, 0);
        cycle(0, 4'b0000, 0);
        repeat (3) cycle(0, 4'b0000, 1);

        // re-request in the accept cycle keeps the bit pending, no done pulse
        cycle(1, 4'b0010, 0);
        cycle(1, 4'b0010, 1);
        cycle(0, 4'b0000, 1);
        cycle(0, 4'b0000, 0);

        // zero load is a no-op; full load drains in four cycles
        cycle(1, 4'b0000, 1);
        cycle(1, 4'b1111, 1);
        repeat (5) cycle(0, 4'b0000, 1);

        // reset dropped mid-serve with pending 1100
        cycle(1, 4'b1100, 0);
        cycle(0, 4'b0000, 0);
        @(negedge clk);
        req_load  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        #1 rst_n = 1'b1;
        apply(0, 4'b0000, 1);
        repeat (2) cycle(0, 4'b0000, 1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            bit         ld;
            bit         rdy;
            logic [3:0] rq;
            ld  = ($urandom_range(0, 3) == 0);
            rq  = 4'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            cycle(ld, rq, rdy);
        end
        repeat (6) cycle(0, 4'b0000, 1);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
